// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared register-file types and sizes used by the write-back
//                path (data width, register address width, register count).
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       word_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. Grants the first requester at or after
//                the rotating pointer (wrapping upward), one-hot. The pointer
//                moves to one past the winner whenever a handshake happens.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               hs,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_ptr_d;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Rotating-priority search: first valid requester starting at rr_ptr.
  always_comb begin
    grant   = '0;
    win_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        win_idx    = idx;
        found      = 1'b1;
      end
    end
  end

  // Pointer moves past the winner only when the grant is actually taken.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs) begin
      rr_ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Write-back arbiter for the 32-entry register file. Shares the
//                single write port between NUM_REQ producers (round-robin,
//                valid/ready), drives a registered write port, and optionally
//                tracks registers with an outstanding write.
//                Optional feature macro: WB_ARBITER_SCOREBOARD_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = rf_pkg::XLEN
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_REQ-1:0]                        req_valid,
  output logic [NUM_REQ-1:0]                        req_ready,
  input  logic [NUM_REQ-1:0][rf_pkg::REG_ADDR_W-1:0] req_rd_addr,
  input  logic [NUM_REQ-1:0][XLEN-1:0]              req_rd_data,
  output logic                                      reg_write,
  output logic [rf_pkg::REG_ADDR_W-1:0]             rd_addr,
  output logic [XLEN-1:0]                           rd_data,
  input  logic                                      issue_valid,
  input  logic [rf_pkg::REG_ADDR_W-1:0]             issue_rd_addr,
  input  logic [rf_pkg::REG_ADDR_W-1:0]             rs1_addr,
  input  logic [rf_pkg::REG_ADDR_W-1:0]             rs2_addr,
  output logic                                      rs1_busy,
  output logic                                      rs2_busy
);

  import rf_pkg::*;

  logic [NUM_REQ-1:0] grant;
  logic               hs;
  reg_addr_t          sel_addr;
  logic [XLEN-1:0]    sel_data;

  logic               reg_write_q;
  logic               reg_write_d;
  reg_addr_t          rd_addr_q;
  reg_addr_t          rd_addr_d;
  logic [XLEN-1:0]    rd_data_q;
  logic [XLEN-1:0]    rd_data_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .hs    (hs),
    .grant (grant)
  );

  // Nothing is granted while reset is held, so no requester believes its
  // write was taken during reset.
  assign req_ready = grant & {NUM_REQ{rst_n}};
  assign hs        = |(req_valid & req_ready);

  // Select the granted requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_rd_addr[i];
        sel_data = req_rd_data[i];
      end
    end
  end

  // Output stage: load on a transfer, pulse write unless the target is x0.
  always_comb begin
    reg_write_d = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    if (hs) begin
      reg_write_d = (sel_addr != '0);
      rd_addr_d   = sel_addr;
      rd_data_d   = sel_data;
    end
  end

  // Registered register-file write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign reg_write = reg_write_q;
  assign rd_addr   = rd_addr_q;
  assign rd_data   = rd_data_q;

`ifdef WB_ARBITER_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Clear on the committing write, then set on issue so a same-cycle
  // re-issue keeps the register busy; x0 can never be busy.
  always_comb begin
    busy_d = busy_q;
    if (reg_write_q) begin
      busy_d[rd_addr_q] = 1'b0;
    end
    if (issue_valid && (issue_rd_addr != '0)) begin
      busy_d[issue_rd_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];
`else
  // Scoreboard absent: ports kept for a stable interface, inputs ignored.
  logic unused_sb;
  assign unused_sb = &{1'b0, issue_valid, issue_rd_addr, rs1_addr, rs2_addr};
  assign rs1_busy  = 1'b0;
  assign rs2_busy  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Self-checking bench for wb_arbiter (NUM_REQ = 2). Expected
//                write-port values are queued when a grant is predicted and
//                compared on the following cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  localparam int NUM_REQ = 2;
  localparam int XLEN    = 32;
`ifdef WB_ARBITER_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b1;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][4:0]       req_rd_addr;
  logic [NUM_REQ-1:0][XLEN-1:0]  req_rd_data;
  logic                          reg_write;
  logic [4:0]                    rd_addr;
  logic [XLEN-1:0]               rd_data;
  logic                          issue_valid;
  logic [4:0]                    issue_rd_addr;
  logic [4:0]                    rs1_addr;
  logic [4:0]                    rs2_addr;
  logic                          rs1_busy;
  logic                          rs2_busy;

  wb_arbiter #(
    .NUM_REQ (NUM_REQ),
    .XLEN    (XLEN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rd_addr   (req_rd_addr),
    .req_rd_data   (req_rd_data),
    .reg_write     (reg_write),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .issue_valid   (issue_valid),
    .issue_rd_addr (issue_rd_addr),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            we;
    logic [4:0]      a;
    logic [XLEN-1:0] d;
  } exp_t;

  exp_t               exp_q[$];
  int                 n_checks = 0;
  int                 n_pass   = 0;
  int                 mptr;
  logic [4:0]         m_addr;
  logic [XLEN-1:0]    m_data;
  logic [31:0]        mbusy;
  logic [NUM_REQ-1:0] last_grant;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: compare outputs at the falling edge, then predict the next.
  task automatic cycle();
    exp_t               e;
    exp_t               n;
    logic [NUM_REQ-1:0] g;
    int                 w;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("exp_queue_empty", 32'd0, 32'd1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check("reg_write", 32'(reg_write), 32'(e.we));
    check("rd_addr",   32'(rd_addr),   32'(e.a));
    check("rd_data",   rd_data,        e.d);
    check("rs1_busy",  32'(rs1_busy),  32'(SB_EN && mbusy[rs1_addr]));
    check("rs2_busy",  32'(rs2_busy),  32'(SB_EN && mbusy[rs2_addr]));
    g = '0;
    w = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (mptr + k) % NUM_REQ;
      if (w < 0 && req_valid[idx]) w = idx;
    end
    if (w >= 0) g[w] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(g));
    last_grant = g;
    n.we = 1'b0;
    n.a  = m_addr;
    n.d  = m_data;
    if (w >= 0) begin
      n.we   = (req_rd_addr[w] != 5'd0);
      n.a    = req_rd_addr[w];
      n.d    = req_rd_data[w];
      m_addr = req_rd_addr[w];
      m_data = req_rd_data[w];
      mptr   = (w + 1) % NUM_REQ;
    end
    exp_q.push_back(n);
    if (e.we) mbusy[e.a] = 1'b0;
    if (issue_valid && issue_rd_addr != 5'd0) mbusy[issue_rd_addr] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Assert reset for one cycle (asynchronously, mid-cycle) and check clearing.
  task automatic do_reset();
    exp_t z;
    rst_n = 1'b0;
    exp_q.delete();
    mptr       = 0;
    m_addr     = '0;
    m_data     = '0;
    mbusy      = '0;
    last_grant = '0;
    @(negedge clk);
    check("rst_reg_write", 32'(reg_write), 32'd0);
    check("rst_rd_addr",   32'(rd_addr),   32'd0);
    check("rst_rd_data",   rd_data,        32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rs1_busy",  32'(rs1_busy),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    z = '0;
    exp_q.push_back(z);
  endtask

  initial begin
    req_valid     = '0;
    req_rd_addr   = '0;
    req_rd_data   = '0;
    issue_valid   = 1'b0;
    issue_rd_addr = '0;
    rs1_addr      = 5'd9;
    rs2_addr      = 5'd3;
    #2;

    // Reset with both requesters valid; first grant afterwards goes to 0.
    req_valid      = 2'b11;
    req_rd_addr[0] = 5'd3;  req_rd_data[0] = 32'h1111_0003;
    req_rd_addr[1] = 5'd7;  req_rd_data[1] = 32'h2222_0007;
    do_reset();
    cycle();
    req_valid = 2'b00;
    cycle();
    cycle();

    // Single write from requester 1.
    req_valid      = 2'b10;
    req_rd_addr[1] = 5'd5;
    req_rd_data[1] = 32'hDEAD_BEEF;
    cycle();
    req_valid = 2'b00;
    cycle();
    cycle();

    // Contention: both valid for four cycles, grants alternate.
    req_valid      = 2'b11;
    req_rd_addr[0] = 5'd3;  req_rd_data[0] = 32'hAAAA_0003;
    req_rd_addr[1] = 5'd7;  req_rd_data[1] = 32'hBBBB_0007;
    repeat (4) cycle();
    req_valid = 2'b00;
    cycle();
    cycle();

    // x0 request: accepted, no write pulse, pointer advances to 1.
    req_valid      = 2'b01;
    req_rd_addr[0] = 5'd0;
    req_rd_data[0] = 32'hC0DE_0000;
    cycle();
    req_valid = 2'b00;
    cycle();
    req_valid      = 2'b11;
    req_rd_addr[0] = 5'd4;
    cycle();
    cycle();
    req_valid = 2'b00;
    cycle();
    cycle();

    // Scoreboard: issue rd=9, write it back, then re-issue during the write.
    rs1_addr      = 5'd9;
    issue_valid   = 1'b1;
    issue_rd_addr = 5'd9;
    cycle();
    issue_valid = 1'b0;
    cycle();
    req_valid      = 2'b01;
    req_rd_addr[0] = 5'd9;
    req_rd_data[0] = 32'h9999_0009;
    cycle();
    req_valid = 2'b00;
    cycle();
    cycle();
    cycle();
    issue_valid = 1'b1;
    cycle();
    issue_valid = 1'b0;
    req_valid      = 2'b10;
    req_rd_addr[1] = 5'd9;
    req_rd_data[1] = 32'h9999_1009;
    cycle();
    req_valid     = 2'b00;
    issue_valid   = 1'b1;
    issue_rd_addr = 5'd9;
    cycle();
    issue_valid = 1'b0;
    cycle();
    cycle();
    issue_valid   = 1'b1;
    issue_rd_addr = 5'd0;
    rs2_addr      = 5'd0;
    cycle();
    issue_valid = 1'b0;
    cycle();

    // Random traffic; a requester keeps its payload until granted.
    req_valid = '0;
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || last_grant[i]) begin
          if ($urandom_range(0, 3) != 0) begin
            req_valid[i]   = 1'b1;
            req_rd_addr[i] = 5'($urandom_range(0, 31));
            req_rd_data[i] = $urandom;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      issue_valid   = 1'($urandom_range(0, 1));
      issue_rd_addr = 5'($urandom_range(0, 31));
      rs1_addr      = 5'($urandom_range(0, 31));
      rs2_addr      = 5'($urandom_range(0, 31));
      cycle();
    end
    issue_valid = 1'b0;

    // Reset while a transfer is in flight: the write is lost, pointer to 0.
    req_valid      = 2'b11;
    req_rd_addr[0] = 5'd12; req_rd_data[0] = 32'h0000_0C0C;
    req_rd_addr[1] = 5'd13; req_rd_data[1] = 32'h0000_0D0D;
    cycle();
    cycle();
    do_reset();
    cycle();
    req_valid = 2'b00;
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
